// File: rtl/shift_arbiter.sv
// Round-robin arbiter for two requesters sharing one 33-bit logical left shifter,
// followed by a two-stage (operand, result) pipeline with result backpressure.

module shift_left #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       amt,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage;

    // Logarithmic barrel: each amount bit shifts by its power of two, zero fill.
    always_comb begin
        stage = data_in;
        for (int i = 0; i < 5; i++) begin
            if (amt[i]) begin
                stage = stage << (1 << i);
            end
        end
        data_out = stage;
    end

endmodule

module shift_arbiter #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_in,
    input  logic [4:0]       req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_in,
    input  logic [4:0]       req1_amt,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_id_q, s1_id_d;
    logic [WIDTH-1:0] s1_in_q, s1_in_d;
    logic [4:0]       s1_amt_q, s1_amt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             last_grant_q, last_grant_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             grant_any;
    logic             grant_id;
    logic [WIDTH-1:0] shift_out;

    shift_left #(.WIDTH(WIDTH)) u_shift_left (
        .data_in  (s1_in_q),
        .amt      (s1_amt_q),
        .data_out (shift_out)
    );

    always_comb begin
        s2_adv     = !rsp_valid_q || rsp_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        grant_any  = s1_adv && (req0_valid || req1_valid);
        // On contention the requester not granted last time wins.
        grant_id   = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
        req0_ready = grant_any && !grant_id;
        req1_ready = grant_any && grant_id;
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_in_d      = s1_in_q;
        s1_amt_d     = s1_amt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;

        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_data_d  = shift_out;
        end

        if (s1_adv) begin
            s1_valid_d = grant_any;
            if (grant_any) begin
                s1_id_d      = grant_id;
                s1_in_d      = grant_id ? req1_in : req0_in;
                s1_amt_d     = grant_id ? req1_amt : req0_amt;
                last_grant_d = grant_id;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_in_q      <= '0;
            s1_amt_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_in_q      <= s1_in_d;
            s1_amt_q     <= s1_amt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized scoreboard bench for shift_arbiter: a two-entry buffer model predicts
// readies and visibility, a negedge monitor pops expected results in order.

module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [32:0] req0_in, req1_in;
    logic [4:0]  req0_amt, req1_amt;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [32:0] rsp_data;
    logic        rsp_ready;

    shift_arbiter #(.WIDTH(33)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_in    (req0_in),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_in    (req1_in),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        id;
        logic [32:0] data;
    } rsp_t;

    rsp_t        sb[$];
    int          inflight[$];
    int          edges;
    bit          last_gnt;
    int          checks;
    int          passes;

    bit          p_v[2];
    logic [32:0] p_in[2];
    logic [4:0]  p_amt[2];
    logic [32:0] p_exp[2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic setReq(input int i, input logic [32:0] in_v, input logic [4:0] amt_v,
                          input logic [32:0] exp_v);
        p_v[i]   = 1'b1;
        p_in[i]  = in_v;
        p_amt[i] = amt_v;
        p_exp[i] = exp_v;
    endtask

    task automatic setRandReq(input int i);
        logic [32:0] v;
        logic [4:0]  a;
        v = {1'($urandom_range(0, 1)), 32'($urandom)};
        a = 5'($urandom_range(0, 31));
        setReq(i, v, a, v << a);
    endtask

    // One clock cycle: drive pending requests, check predicted readies, update model.
    task automatic applyStimulus(input bit rr);
        bit vis, space, any, gid, g0, g1;
        req0_valid = p_v[0];
        req0_in    = p_in[0];
        req0_amt   = p_amt[0];
        req1_valid = p_v[1];
        req1_in    = p_in[1];
        req1_amt   = p_amt[1];
        rsp_ready  = rr;
        #1;
        vis   = (inflight.size() > 0) && (inflight[0] <= edges);
        space = (inflight.size() < 2) || (vis && rr);
        any   = p_v[0] || p_v[1];
        gid   = (p_v[0] && p_v[1]) ? !last_gnt : p_v[1];
        g0    = space && any && !gid;
        g1    = space && any && gid;
        checkOutput("req0_ready", 64'(req0_ready), 64'(g0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(g1));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(vis));
        if (vis && sb.size() > 0) checkOutput("rsp_data_head", 64'(rsp_data), 64'(sb[0].data));
        @(posedge clock);
        #1;
        edges++;
        if (vis && rr) void'(inflight.pop_front());
        if (g0 || g1) begin
            inflight.push_back(edges + 1);
            sb.push_back('{id: gid, data: p_exp[gid]});
            last_gnt = gid;
            p_v[gid] = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (sb.size() > 0 || p_v[0] || p_v[1]); c++) applyStimulus(1'b1);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic modelReset();
        sb.delete();
        inflight.delete();
        last_gnt = 1'b1;
        p_v[0]   = 1'b0;
        p_v[1]   = 1'b0;
    endtask

    // Monitor: a handshake is visible mid-cycle; pop and compare in acceptance order.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_rsp: got id %0d data %0h expected none", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                    checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    logic [32:0] dir_in[5]  = '{33'h0_0000_0001, 33'h0_0001_2345, 33'h1_FFFF_FFFF,
                                33'h1_FFFF_FFFF, 33'h1_0000_0000};
    logic [4:0]  dir_amt[5] = '{5'd31, 5'd16, 5'd0, 5'd1, 5'd1};
    logic [32:0] dir_exp[5] = '{33'h0_8000_0000, 33'h1_2345_0000, 33'h1_FFFF_FFFF,
                                33'h1_FFFF_FFFE, 33'h0_0000_0000};

    initial begin
        checks = 0;
        passes = 0;
        edges  = 0;
        modelReset();
        p_in[0] = '0; p_in[1] = '0; p_amt[0] = '0; p_amt[1] = '0;
        p_exp[0] = '0; p_exp[1] = '0;
        reset_n    = 1'b0;
        req0_valid = 1'b0; req0_in = '0; req0_amt = '0;
        req1_valid = 1'b0; req1_in = '0; req1_amt = '0;
        rsp_ready  = 1'b0;
        #12;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_req0_ready", 64'(req0_ready), 64'd0);
        checkOutput("reset_req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] directed shift vectors");
        for (int k = 0; k < 5; k++) begin
            setReq(0, dir_in[k], dir_amt[k], dir_exp[k]);
            applyStimulus(1'b1);
            applyStimulus(1'b1);
        end
        drain(10);

        $display("[TB] round-robin contention");
        for (int c = 0; c < 6; c++) begin
            if (!p_v[0]) setRandReq(0);
            if (!p_v[1]) setRandReq(1);
            applyStimulus(1'b1);
        end
        drain(10);

        $display("[TB] backpressure");
        for (int c = 0; c < 5; c++) begin
            if (!p_v[0]) setRandReq(0);
            if (!p_v[1]) setRandReq(1);
            applyStimulus(1'b0);
        end
        drain(20);

        $display("[TB] pointer holds across idle");
        setRandReq(1);
        applyStimulus(1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1);
        setRandReq(0);
        setRandReq(1);
        applyStimulus(1'b1);
        drain(10);

        $display("[TB] reset mid-flight");
        setRandReq(1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midreset_rsp_data", 64'(rsp_data), 64'd0);
        modelReset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus(1'b1);
        setRandReq(0);
        setRandReq(1);
        applyStimulus(1'b1);
        drain(10);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            if (!p_v[0] && $urandom_range(0, 9) < 6) setRandReq(0);
            if (!p_v[1] && $urandom_range(0, 9) < 6) setRandReq(1);
            applyStimulus(1'($urandom_range(0, 9) < 7));
        end
        drain(30);

        applyStimulus(1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester, round-robin arbiter and 2-stage pipeline wrapped around one 33-bit logical left barrel shifter (`shift_left`). It lets the multiplier's shift-and-add sequencer (requester 0) and the ALU shift path (requester 1) share a single shifter instance. Each requester uses a valid/ready handshake on the request side. A single tagged result port with backpressure carries results back.

## Interface
- `WIDTH`, 33: operand and result width. Fixed by `shift_left`, so no other value is supported.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_in` in 33: requester 0 operand.
- `req0_amt` in 5: requester 0 shift amount, 0–31.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req1_valid`, `req1_in`, `req1_amt`, `req1_ready`: same signals for requester 1.
- `rsp_valid` out 1: a result is held on `rsp_data`.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out 33: the value `in << amt`.
- `rsp_ready` in 1: the consumer takes the result this cycle.

## Operation
- **Shift arithmetic:** 33-bit logical left shift with zero fill. Bits shifted past bit 32 are discarded, and bit 32 of the operand is kept only when amt=0. The width is never extended.
- **Stage S1 (operand register):** holds `s1_valid`, `s1_id`, `s1_in` and `s1_amt`. It drives the `shift_left` instance combinationally.
- **Stage S2 (result register):** holds `rsp_valid`, `rsp_id` and `rsp_data`. It captures the shifter output.
- **S2 advance:** `s2_adv = !rsp_valid || rsp_ready`.
  - When `s2_adv` is high, S2 loads S1's contents. `rsp_valid` then takes the value of `s1_valid`.
- **S1 advance:** `s1_adv = !s1_valid || s2_adv`.
  - When `s1_adv` is high, S1 loads the granted request, or becomes invalid if there is no grant.
- **Grant:** issued only when `s1_adv` is high.
  - If exactly one requester is valid, that requester wins.
  - If both are valid, the requester that was not granted last wins.
- **Ready:** `reqN_ready` = `s1_adv` && grant to N. It is combinational from valid, rsp_ready and state.
- **Pointer:** `last_grant` updates only on an actual grant. It is unchanged on idle cycles and stall cycles.
- **Request rule:** a requester must hold valid and its payload stable until ready. The arbiter never drops or duplicates an accepted request.
- **Output order:** results leave in acceptance order.

## Timing
- **Reset values (asynchronous):**
  - `s1_valid`=0 and `rsp_valid`=0.
  - `rsp_id`=0 and `rsp_data`=0.
  - S1 payload = 0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - `req0_ready` and `req1_ready` are 0 only because no request is valid. They follow the combinational rule as soon as valid rises after reset.
- **Latency:** a request accepted at edge N appears with `rsp_valid`=1 after edge N+1 (2-cycle latency).
- **Throughput:** one request per cycle with no stall.
- **Full pipeline:** both stages valid and `rsp_ready`=0 → both readys are 0 and all registers hold.
- **Single bubble:** S1 empty but S2 stalled → S1 still accepts one more request, which gives two requests of buffering.
- **Simultaneous accept and drain:** S2 drains and S1 advances in the same cycle, so there is no bubble.
- **Reset mid-operation:** in-flight S1 and S2 contents are discarded. No result is emitted for them after reset release.
- **Contention pattern:** both requesters continuously valid with `rsp_ready`=1 → grants alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- **Single request and shift width:**
  - req0 in=33'h0_0000_0001, amt=31 → two cycles later `rsp_valid`=1, id=0, data=33'h0_8000_0000.
  - Then in=33'h0_0001_2345, amt=16 → 33'h1_2345_0000.
- **Boundary amounts:**
  - in=33'h1_FFFF_FFFF, amt=0 → 33'h1_FFFF_FFFF.
  - Same in, amt=1 → 33'h1_FFFF_FFFE.
  - in=33'h1_0000_0000, amt=1 → 33'h0_0000_0000.
- **Round-robin:** both requesters valid for 6 cycles with `rsp_ready`=1 → rsp_id sequence is 0,1,0,1,0,1 and each data value matches its own requester's operand.
- **Backpressure:**
  - Hold `rsp_ready`=0 with both requesters valid → exactly two accepts, then both readys stay 0 and `rsp_data` stays stable.
  - Release `rsp_ready` → remaining results arrive in order with no loss or duplicate.
- **Pointer holds across idle:** grant to 1, then 3 idle cycles, then both valid → requester 0 granted.
- **Reset mid-flight:** accept req1, then assert `reset_n`=0 for 1 cycle before the result drains → `rsp_valid`=0 immediately. No stale response appears after release, and the next contention goes to requester 0.
